tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the 4:1 multiplexer link. It sequences the slot address that drives the remote 4:1 multiplexer selects, collects one sample per slot from the serial stream, and presents all four channels as one parallel word at the end of each frame. Framing is recovered from a slot-0 sync strobe.

## Interface
- WIDTH, 1, bits per channel sample
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- frame_sync  in  1  high in the cycle whose din is slot 0
- din  in  WIDTH  serial sample for the current slot
- address0  out  1  slot LSB, drives the remote mux address0
- address1  out  1  slot MSB, drives the remote mux address1
- out0..out3  out  WIDTH each  parallel channel words from the last complete frame
- frame_valid  out  1  one-cycle pulse when out0..out3 update
- locked  out  1  high while in LOCKED
- sync_err  out  1  one-cycle pulse on a framing violation

## Operation
- The 2-bit slot register gives the slot of the din sampled at the next edge. {address1,address0} = slot, so address0 is the LSB and slot 1 is address0=1, address1=0.
- States: HUNT and LOCKED.
- **HUNT**
  - slot held at 0; din ignored while frame_sync=0.
  - frame_sync=1: shadow0<=din, slot<=1, go to LOCKED.
- **LOCKED**, each edge:
  - slot 1 or 2, no sync: shadow[slot]<=din, slot<=slot+1.
  - slot 3, no sync: out0..out2<=shadow0..2, out3<=din, frame_valid<=1, slot<=0 (wraps).
  - slot 0 with frame_sync=1: shadow0<=din, slot<=1.
  - frame_sync=1 at slot≠0 (early sync): sync_err pulse, partial frame discarded (no frame_valid), shadow0<=din, slot<=1, stay LOCKED.
  - slot 0 with frame_sync=0 (missed sync): behaviour set by the configuration macro.
- out0..out3 change only with frame_valid; they hold their values between frames and through HUNT.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: slot=0, address0=address1=0, out0..out3=0, frame_valid=0, sync_err=0, locked=0, state=HUNT, shadows=0.
- rst_n deassertion mid-frame discards the frame. The first sync is accepted on the first edge after release.
- Latency: a frame occupies 4 consecutive cycles. out*/frame_valid are visible one clock after the edge that samples slot 3. Back-to-back frames give frame_valid every 4th cycle.
- locked rises on the edge after the accepted frame_sync.
- frame_valid and sync_err are each high for exactly one cycle and are never high together.

## Configuration
- TDM_DEMUX_SYNC_CHECK_EN defined: a missed sync at slot 0 while LOCKED pulses sync_err, discards the sample, returns to HUNT (locked<=0, slot<=0).
- Not defined (flywheel): a missed sync is treated as slot 0 (shadow0<=din, slot<=1), with no sync_err. Early-sync resync and its sync_err apply in both builds.

## Structure
- Package tdm_pkg: NUM_SLOTS=4, SLOT_W=2, state enum {HUNT, LOCKED}.
- One sub-module, tdm_slot_counter. It holds the 2-bit wrapping counter with sync-load-to-1 and hold-at-0 controls, and its output drives address0/address1.
- Shadow/output registers and the FSM live in tdm_demux4.

## Test plan
- **Reset and idle:** assert rst_n=0, then release with frame_sync=0 for 10 cycles → all outputs 0, locked=0, address=00.
- **Single frame:** WIDTH=4; frame_sync=1 with din=4'hA, then 4'h1, 4'h2, 4'h3 → address sequence 00,01,10,11; out0..3=A,1,2,3 with one frame_valid pulse one clock after the slot-3 edge; locked=1.
- **Back-to-back frames:** three frames with sync every 4th cycle → frame_valid every 4 cycles, address wraps 11→00, outputs track each frame.
- **Early sync:** frame_sync=1 at slot 2 → sync_err single pulse, no frame_valid for the partial frame, next frame aligned to the new sync, old outputs held.
- **Missed sync:** drop frame_sync at slot 0.
  - With TDM_DEMUX_SYNC_CHECK_EN: sync_err pulse, locked=0, address=00 until the next sync.
  - Without it: no sync_err, the frame completes normally.
- **Reset mid-frame:** drive rst_n=0 at slot 2 → outputs cleared asynchronously; after release, the first frame needs a new sync.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

    function automatic slot_t next_slot(input slot_t s);
        return s + slot_t'(1);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter; its value drives the remote mux address lines.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  load,
    input  logic  inc,
    output slot_t slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else begin
            unique case (1'b1)
                clr:     slot <= '0;
                load:    slot <= slot_t'(1);
                inc:     slot <= next_slot(slot);
                default: slot <= slot;
            endcase
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demux with sync-strobe framing.
// Define TDM_DEMUX_SYNC_CHECK_EN to drop lock on a missed slot-0 sync.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_sync,
    input  logic [WIDTH-1:0] din,
    output logic             address0,
    output logic             address1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    state_t           state;
    slot_t            slot;
    logic [WIDTH-1:0] shadow0;
    logic [WIDTH-1:0] shadow1;
    logic [WIDTH-1:0] shadow2;

    logic hunt, resync, missed, last, mid;
    logic cnt_clr, cnt_load, cnt_inc;

    // Mutually exclusive decode of the current cycle's event.
    assign hunt   = (state == HUNT);
    assign resync = !hunt && frame_sync;
    assign missed = !hunt && !frame_sync && (slot == '0);
    assign last   = !hunt && !frame_sync && (slot == LAST_SLOT);
    assign mid    = !hunt && !frame_sync && !missed && !last;

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        unique case (1'b1)
            hunt:   begin
                cnt_load = frame_sync;
                cnt_clr  = !frame_sync;
            end
            resync: cnt_load = 1'b1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            missed: cnt_clr  = 1'b1;
`else
            missed: cnt_load = 1'b1;
`endif
            default: cnt_inc = 1'b1;
        endcase
    end

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .slot  (slot)
    );

    assign address0 = slot[0];
    assign address1 = slot[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            locked      <= 1'b0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            shadow0     <= '0;
            shadow1     <= '0;
            shadow2     <= '0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            unique case (1'b1)
                hunt: begin
                    if (frame_sync) begin
                        shadow0 <= din;
                        state   <= LOCKED;
                        locked  <= 1'b1;
                    end
                end
                resync: begin
                    // Sync anywhere but slot 0 abandons the partial frame.
                    sync_err <= (slot != '0);
                    shadow0  <= din;
                end
                missed: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    sync_err <= 1'b1;
                    state    <= HUNT;
                    locked   <= 1'b0;
`else
                    shadow0  <= din;
`endif
                end
                last: begin
                    out0        <= shadow0;
                    out1        <= shadow1;
                    out2        <= shadow2;
                    out3        <= din;
                    frame_valid <= 1'b1;
                end
                mid: begin
                    if (slot == slot_t'(1)) shadow1 <= din;
                    else                    shadow2 <= din;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=4).
module tb_tdm_demux4;

    logic       clk;
    logic       rst_n;
    logic       frame_sync;
    logic [3:0] din;
    logic       address0;
    logic       address1;
    logic [3:0] out0;
    logic [3:0] out1;
    logic [3:0] out2;
    logic [3:0] out3;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_sync  (frame_sync),
        .din         (din),
        .address0    (address0),
        .address1    (address1),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic fs, input logic [3:0] d);
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [1:0] addr,
                          input logic fv, input logic lk, input logic se);
        chk({tag, ".addr"}, 32'({address1, address0}), 32'(addr));
        chk({tag, ".fv"},   32'(frame_valid), 32'(fv));
        chk({tag, ".lock"}, 32'(locked), 32'(lk));
        chk({tag, ".serr"}, 32'(sync_err), 32'(se));
    endtask

    task automatic chk_out(input string tag, input logic [15:0] exp);
        chk({tag, ".out"}, 32'({out0, out1, out2, out3}), 32'(exp));
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_sync = 1'b0;
        din        = 4'h0;
        #11;
        chk_st("rst", 2'b00, 1'b0, 1'b0, 1'b0);
        chk_out("rst", 16'h0000);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'(i + 3));
            chk_st("idle", 2'b00, 1'b0, 1'b0, 1'b0);
        end
        chk_out("idle", 16'h0000);

        step(1'b1, 4'hA); chk_st("f1s0", 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h1); chk_st("f1s1", 2'b10, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h2); chk_st("f1s2", 2'b11, 1'b0, 1'b1, 1'b0);
        chk_out("f1pre", 16'h0000);
        step(1'b0, 4'h3); chk_st("f1s3", 2'b00, 1'b1, 1'b1, 1'b0);
        chk_out("f1", 16'hA123);

        step(1'b1, 4'h4); chk_st("f2s0", 2'b01, 1'b0, 1'b1, 1'b0);
        chk_out("f2hold", 16'hA123);
        step(1'b0, 4'h5); chk_st("f2s1", 2'b10, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h6); chk_st("f2s2", 2'b11, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h7); chk_st("f2s3", 2'b00, 1'b1, 1'b1, 1'b0);
        chk_out("f2", 16'h4567);

        step(1'b1, 4'hB); chk_st("f3s0", 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'hC);
        step(1'b0, 4'hD); chk_st("f3s2", 2'b11, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'hE); chk_st("f3s3", 2'b00, 1'b1, 1'b1, 1'b0);
        chk_out("f3", 16'hBCDE);

        step(1'b1, 4'h1);
        step(1'b0, 4'h2); chk_st("es_s1", 2'b10, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h9); chk_st("early", 2'b01, 1'b0, 1'b1, 1'b1);
        chk_out("early_hold", 16'hBCDE);
        step(1'b0, 4'h8); chk_st("es_n1", 2'b10, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h7); chk_st("es_n2", 2'b11, 1'b0, 1'b1, 1'b0);
        chk_out("es_hold", 16'hBCDE);
        step(1'b0, 4'h6); chk_st("es_n3", 2'b00, 1'b1, 1'b1, 1'b0);
        chk_out("es_frame", 16'h9876);

`ifdef TDM_DEMUX_SYNC_CHECK_EN
        step(1'b0, 4'h5); chk_st("miss", 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h4); chk_st("miss_h", 2'b00, 1'b0, 1'b0, 1'b0);
        chk_out("miss_hold", 16'h9876);
        step(1'b1, 4'h1); chk_st("rl_s0", 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h2);
        step(1'b0, 4'h3);
        step(1'b0, 4'h4); chk_st("rl_s3", 2'b00, 1'b1, 1'b1, 1'b0);
        chk_out("rl", 16'h1234);
`else
        step(1'b0, 4'h5); chk_st("fly_s0", 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h4);
        step(1'b0, 4'h3); chk_st("fly_s2", 2'b11, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h2); chk_st("fly_s3", 2'b00, 1'b1, 1'b1, 1'b0);
        chk_out("fly", 16'h5432);
`endif

        step(1'b1, 4'hF);
        step(1'b0, 4'hE); chk_st("mr_s1", 2'b10, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_st("mr_async", 2'b00, 1'b0, 1'b0, 1'b0);
        chk_out("mr_async", 16'h0000);
        #1 rst_n = 1'b1;
        step(1'b0, 4'h1); chk_st("mr_h1", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h2);
        step(1'b0, 4'h3); chk_st("mr_h3", 2'b00, 1'b0, 1'b0, 1'b0);
        chk_out("mr_h3", 16'h0000);
        step(1'b1, 4'h5); chk_st("mr_s0", 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h6);
        step(1'b0, 4'h7);
        step(1'b0, 4'h8); chk_st("mr_s3", 2'b00, 1'b1, 1'b1, 1'b0);
        chk_out("mr", 16'h5678);
        step(1'b1, 4'h0); chk_st("mr_end", 2'b01, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
